ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch stage of the pipelined CPU, sitting between `program_counter` and the IF/ID boundary.
- Takes the current PC, issues one request at a time to instruction memory over a valid/ready interface, and waits for the response.
- Registers the fetched instruction into IF/ID, with a one-entry hold buffer for decode back-pressure.
- Generates the `stall` that freezes `program_counter`, and handles taken-branch redirects by discarding in-flight fetches.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- NOP_INSTR, 32'h00000013, instruction substituted on a fetch fault (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  XLEN  current PC from program_counter.pc_out.
- pc_stall  out  1  drives program_counter.stall; 0 lets the PC load pc_next.
- redirect  in  1  taken branch/jump from EX; flush fetch.
- id_stall  in  1  decode cannot accept a new IF/ID entry.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid (single-cycle pulse, at most one per accepted request).
- imem_rsp_data  in  ILEN  fetched instruction.
- imem_rsp_err  in  1  access fault for this response.
- if_id_valid  out  1  IF/ID entry valid.
- if_id_pc  out  XLEN  PC of the IF/ID instruction.
- if_id_instr  out  ILEN  IF/ID instruction.
- if_id_fault  out  1  IF/ID instruction came from a faulted fetch.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - state=IDLE, drop=0, hold buffer empty.
  - Register outputs: if_id_valid=0, if_id_pc=0, if_id_instr=0, if_id_fault=0.
  - Decoded outputs in IDLE: imem_req_valid=0, pc_stall=1.
- States IDLE, REQ, WAIT, HOLD, DRAIN; pc_stall=1 in every cycle except where a release is stated below.
- IDLE -> REQ unconditionally, one cycle after reset deasserts.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_in.
  - On imem_req_ready: latch req_pc=pc_in, go WAIT.
- WAIT: on imem_rsp_valid, form entry {req_pc, data or NOP_INSTR if err, err}.
  - If id_stall=0 or if_id_valid=0: load IF/ID with if_id_valid=1, pulse pc_stall=0 this cycle, go REQ.
  - Else: write entry to hold buffer, go HOLD.
  - Fetch latency, measured from request acceptance to IF/ID valid, = memory latency + 1 cycle.
- HOLD: when id_stall=0, move buffer to IF/ID, pulse pc_stall=0, go REQ.
- IF/ID consumption: when id_stall=0 and no new entry loads this cycle, if_id_valid<=0 (bubble). When id_stall=1, all if_id_* hold.
- redirect=1 (highest priority, any state except IDLE):
  - pc_stall=0 that cycle so the PC loads the branch target.
  - if_id_valid<=0; hold buffer cleared.
  - If a request is outstanding (WAIT with no rsp this cycle, or REQ with imem_req_ready=1 this cycle): go DRAIN. Otherwise go REQ.
  - A response arriving in the redirect cycle is discarded.
  - REQ with ready=0 simply re-issues next cycle with the new pc_in.
- DRAIN:
  - imem_req_valid=0.
  - On imem_rsp_valid: discard the response, go REQ.
  - A second redirect in DRAIN stays in DRAIN and still releases pc_stall for one cycle.
- Handshake rules:
  - imem_req_addr is stable while imem_req_valid=1 and ready=0.
  - The request is withdrawn only on redirect.
  - Never more than one outstanding request.
- A PC advance happens exactly once per IF/ID load and once per redirect; pc_in is never sampled outside REQ.
- id_stall is ignored while if_id_valid=0.

Test Plan:
- Reset release, memory ready=1, 1-cycle latency, PC starts 0x0 -> requests at 0x0, 0x4, 0x8; IF/ID shows (0x0, instr0), (0x4, instr1) in order. pc_stall low exactly one cycle per fetch; every reset output reads 0 beforehand.
- id_stall=1 for 4 cycles while a response for 0x8 arrives -> entry goes to HOLD and pc_stall stays 1. IF/ID keeps the 0x4 instruction. On id_stall=0, (0x8, instr2) loads and pc_stall pulses low once.
- redirect in WAIT, target 0x100, response arrives 2 cycles later -> response dropped, FSM passes through DRAIN, next request addr=0x100. if_id_valid=0 until the 0x100 instruction arrives.
- imem_rsp_err=1 on fetch of 0x40 -> if_id_instr=32'h00000013, if_id_fault=1, if_id_pc=0x40. The next fetch at 0x44 shows fault=0.
- imem_req_ready held 0 for 3 cycles -> imem_req_valid=1 and imem_req_addr constant over all 3 cycles, pc_stall=1 throughout. Redirect in the 3rd cycle changes the address next cycle with no DRAIN.
- Async reset asserted while in WAIT with a late response pending -> state IDLE and if_id_valid=0 immediately. The stale response after reset is ignored (no IF/ID load).

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch into IF/ID with a hold buffer and redirect drain
module ifetch_unit #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_stall,
  input  logic            redirect,
  input  logic            id_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instr,
  output logic            if_id_fault
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] req_pc, hold_pc;
  logic [ILEN-1:0] hold_instr, rsp_instr;
  logic hold_fault, flush, take, load_rsp, load_hold, to_hold, outstanding;
  assign rsp_instr = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
  assign flush = redirect && state != S_IDLE;
  assign take = !id_stall || !if_id_valid;
  assign load_rsp = state == S_WAIT && imem_rsp_valid && !flush && take;
  assign load_hold = state == S_HOLD && !flush && take;
  assign to_hold = state == S_WAIT && imem_rsp_valid && !flush && !take;
  assign outstanding = ((state == S_WAIT || state == S_DRAIN) && !imem_rsp_valid) ||
                       (state == S_REQ && imem_req_ready);
  assign pc_stall = !(flush || load_rsp || load_hold);
  assign imem_req_valid = state == S_REQ;
  assign imem_req_addr = pc_in;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = S_REQ;
      S_REQ:   state_n = imem_req_ready ? S_WAIT : S_REQ;
      S_WAIT:  state_n = !imem_rsp_valid ? S_WAIT : take ? S_REQ : S_HOLD;
      S_HOLD:  state_n = take ? S_REQ : S_HOLD;
      S_DRAIN: state_n = imem_rsp_valid ? S_REQ : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = outstanding ? S_DRAIN : S_REQ;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_pc      <= '0;
      hold_pc     <= '0;
      hold_instr  <= '0;
      hold_fault  <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_fault <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_REQ && imem_req_ready) req_pc <= pc_in;
      if (to_hold) begin
        hold_pc    <= req_pc;
        hold_instr <= rsp_instr;
        hold_fault <= imem_rsp_err;
      end
      if (flush) if_id_valid <= 1'b0;
      else if (load_rsp) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_instr <= rsp_instr;
        if_id_fault <= imem_rsp_err;
      end else if (load_hold) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= hold_pc;
        if_id_instr <= hold_instr;
        if_id_fault <= hold_fault;
      end else if (!id_stall) if_id_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit against a simple program_counter model
module tb_ifetch_unit;
  logic clk = 0, reset = 1;
  logic [63:0] pc, tgt = '0;
  logic pc_stall, redirect = 0, id_stall = 0;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, imem_rsp_err = 0;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_rsp_data = '0;
  logic if_id_valid, if_id_fault;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  int passed = 0, total = 0;
  localparam logic [31:0] I0 = 32'h11111111, I1 = 32'h22222222, I2 = 32'h33333333;
  localparam logic [31:0] I100 = 32'h44444444, I44 = 32'h55555555, BAD = 32'hdeadbeef;
  ifetch_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc), .pc_stall(pc_stall), .redirect(redirect),
    .id_stall(id_stall), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_fault(if_id_fault)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else if (!pc_stall) pc <= redirect ? tgt : pc + 64'd4;
  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask
  task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic chka(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic chk_ifid(input string tag, input logic [63:0] p, input logic [31:0] i, input logic f);
    chkb({tag, "_valid"}, if_id_valid, 1'b1);
    chka({tag, "_pc"}, if_id_pc, p);
    chki({tag, "_instr"}, if_id_instr, i);
    chkb({tag, "_fault"}, if_id_fault, f);
  endtask
  initial begin
    #1;
    chkb("rst_valid", if_id_valid, 1'b0);
    chka("rst_pc", if_id_pc, 64'h0);
    chki("rst_instr", if_id_instr, 32'h0);
    chkb("rst_fault", if_id_fault, 1'b0);
    chkb("rst_req", imem_req_valid, 1'b0);
    chkb("rst_stall", pc_stall, 1'b1);
    step; step;
    reset = 0;
    #1;
    chkb("idle_req", imem_req_valid, 1'b0);
    chkb("idle_stall", pc_stall, 1'b1);
    step;
    imem_req_ready = 1;
    #1;
    chkb("req0_valid", imem_req_valid, 1'b1);
    chka("req0_addr", imem_req_addr, 64'h0);
    chkb("req0_stall", pc_stall, 1'b1);
    step;
    imem_rsp_valid = 1; imem_rsp_data = I0;
    #1;
    chkb("wait0_req", imem_req_valid, 1'b0);
    chkb("wait0_stall", pc_stall, 1'b0);
    step;
    imem_rsp_valid = 0;
    #1;
    chk_ifid("ifid0", 64'h0, I0, 1'b0);
    chka("req4_addr", imem_req_addr, 64'h4);
    chkb("req4_stall", pc_stall, 1'b1);
    step;
    imem_rsp_valid = 1; imem_rsp_data = I1;
    #1;
    chkb("bubble0", if_id_valid, 1'b0);
    chkb("wait4_stall", pc_stall, 1'b0);
    step;
    imem_rsp_valid = 0; id_stall = 1;
    #1;
    chk_ifid("ifid4", 64'h4, I1, 1'b0);
    chka("req8_addr", imem_req_addr, 64'h8);
    step;
    imem_rsp_valid = 1; imem_rsp_data = I2;
    #1;
    chkb("wait8_stall", pc_stall, 1'b1);
    step;
    imem_rsp_valid = 0;
    #1;
    chkb("hold1_stall", pc_stall, 1'b1);
    chkb("hold1_req", imem_req_valid, 1'b0);
    chk_ifid("hold1_ifid", 64'h4, I1, 1'b0);
    step;
    #1;
    chkb("hold2_stall", pc_stall, 1'b1);
    chka("hold2_ifid_pc", if_id_pc, 64'h4);
    id_stall = 0;
    #1;
    chkb("hold_release", pc_stall, 1'b0);
    step;
    #1;
    chk_ifid("ifid8", 64'h8, I2, 1'b0);
    chka("reqC_addr", imem_req_addr, 64'hC);
    chkb("reqC_stall", pc_stall, 1'b1);
    step;
    redirect = 1; tgt = 64'h100;
    #1;
    chkb("redir_stall", pc_stall, 1'b0);
    step;
    redirect = 0;
    #1;
    chkb("drain_req", imem_req_valid, 1'b0);
    chkb("drain_ifid", if_id_valid, 1'b0);
    chkb("drain_stall", pc_stall, 1'b1);
    step;
    imem_rsp_valid = 1; imem_rsp_data = BAD;
    #1;
    chkb("drain_rsp_stall", pc_stall, 1'b1);
    chkb("drain_rsp_req", imem_req_valid, 1'b0);
    step;
    imem_rsp_valid = 0;
    #1;
    chkb("req100_valid", imem_req_valid, 1'b1);
    chka("req100_addr", imem_req_addr, 64'h100);
    chkb("req100_ifid", if_id_valid, 1'b0);
    step;
    imem_rsp_valid = 1; imem_rsp_data = I100;
    #1;
    chkb("wait100_ifid", if_id_valid, 1'b0);
    step;
    imem_rsp_valid = 0; imem_req_ready = 0;
    #1;
    chk_ifid("ifid100", 64'h100, I100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        redirect = 1; tgt = 64'h40;
        #1;
        chkb("nr_redir_stall", pc_stall, 1'b0);
      end else begin
        #1;
        chkb("nr_stall", pc_stall, 1'b1);
      end
      chkb("nr_valid", imem_req_valid, 1'b1);
      chka("nr_addr", imem_req_addr, 64'h104);
      step;
    end
    redirect = 0; imem_req_ready = 1;
    #1;
    chkb("req40_valid", imem_req_valid, 1'b1);
    chka("req40_addr", imem_req_addr, 64'h40);
    step;
    imem_rsp_valid = 1; imem_rsp_err = 1; imem_rsp_data = BAD;
    #1;
    chkb("wait40_stall", pc_stall, 1'b0);
    step;
    imem_rsp_valid = 0; imem_rsp_err = 0;
    #1;
    chk_ifid("ifid40", 64'h40, 32'h00000013, 1'b1);
    chka("req44_addr", imem_req_addr, 64'h44);
    step;
    imem_rsp_valid = 1; imem_rsp_data = I44;
    step;
    imem_rsp_valid = 0; id_stall = 1;
    #1;
    chk_ifid("ifid44", 64'h44, I44, 1'b0);
    chka("req48_addr", imem_req_addr, 64'h48);
    step;
    #1;
    chkb("wait48_ifid", if_id_valid, 1'b1);
    reset = 1;
    #1;
    chkb("arst_valid", if_id_valid, 1'b0);
    chka("arst_pc", if_id_pc, 64'h0);
    chkb("arst_req", imem_req_valid, 1'b0);
    chkb("arst_stall", pc_stall, 1'b1);
    step;
    reset = 0; id_stall = 0; imem_rsp_valid = 1; imem_rsp_data = BAD;
    #1;
    chkb("stale_stall", pc_stall, 1'b1);
    step;
    imem_rsp_valid = 0;
    #1;
    chkb("stale_ifid", if_id_valid, 1'b0);
    chkb("post_req", imem_req_valid, 1'b1);
    chka("post_addr", imem_req_addr, 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
